// File: rtl/grey_binarize.sv
// grey_binarize: 3-stage grey-to-RGB444 binarizer with optional frame-mean threshold.
// Define GREY_BINARIZE_ADAPTIVE_EN to enable the adaptive (frame-mean) threshold.
`default_nettype none

module grey_binarize #(
  parameter logic [7:0] THRESH_DEFAULT = 8'd128,
  parameter int         CNT_W          = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_href,
  input  logic        in_vsync,
  input  logic        in_clken,
  input  logic [7:0]  grey,
  output logic [11:0] out_rgb,
  output logic        out_href,
  output logic        out_vsync,
  output logic        out_clken,
  output logic [7:0]  threshold,
  output logic        th_update
);

  localparam int SUM_W = CNT_W + 8;

  logic [7:0]  grey_q;
  logic        bin_q;
  logic [11:0] rgb_q;
  logic [2:0]  href_sr_q;
  logic [2:0]  vsync_sr_q;
  logic [2:0]  clken_sr_q;
  logic [7:0]  thresh_cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grey_q     <= '0;
      bin_q      <= 1'b0;
      rgb_q      <= '0;
      href_sr_q  <= '0;
      vsync_sr_q <= '0;
      clken_sr_q <= '0;
    end else begin
      grey_q     <= grey;
      bin_q      <= (grey_q >= thresh_cur);
      rgb_q      <= {12{bin_q}};
      href_sr_q  <= {href_sr_q[1:0], in_href};
      vsync_sr_q <= {vsync_sr_q[1:0], in_vsync};
      clken_sr_q <= {clken_sr_q[1:0], in_clken};
    end
  end

  assign out_rgb   = rgb_q;
  assign out_href  = href_sr_q[2];
  assign out_vsync = vsync_sr_q[2];
  assign out_clken = clken_sr_q[2];
  assign threshold = thresh_cur;

`ifdef GREY_BINARIZE_ADAPTIVE_EN

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int               ITER_W  = $clog2(SUM_W);
  localparam logic [SUM_W-1:0] SUM_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic               vsync_d_q;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [7:0]         thresh_q, thresh_d;
  logic               th_upd_q;

  logic               vs_rise;
  logic               pix_ok;
  logic [SUM_W:0]     sum_ext;
  logic [CNT_W:0]     trial;
  logic [CNT_W:0]     diff;

  assign vs_rise = in_vsync & ~vsync_d_q;
  assign pix_ok  = in_href & in_clken;
  assign sum_ext = {1'b0, sum_q} + (SUM_W+1)'(grey);
  // Quotient register starts as the dividend; its MSB shifts into the remainder each step.
  assign trial   = {rem_q, quo_q[SUM_W-1]};
  assign diff    = trial - {1'b0, div_q};

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    count_d  = count_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    iter_d   = iter_q;
    thresh_d = thresh_q;

    if (vs_rise) begin
      sum_d   = pix_ok ? SUM_W'(grey) : '0;
      count_d = CNT_W'(pix_ok);
    end else if (pix_ok) begin
      sum_d   = sum_ext[SUM_W] ? SUM_MAX : sum_ext[SUM_W-1:0];
      count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
    end

    case (state_q)
      ACCUM: begin
        if (vs_rise && (count_q != '0)) begin
          quo_d   = sum_q;
          div_d   = count_q;
          rem_d   = '0;
          iter_d  = ITER_W'(SUM_W - 1);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (trial >= {1'b0, div_q}) begin
          rem_d = diff[CNT_W-1:0];
          quo_d = {quo_q[SUM_W-2:0], 1'b1};
        end else begin
          rem_d = trial[CNT_W-1:0];
          quo_d = {quo_q[SUM_W-2:0], 1'b0};
        end
        if (iter_q == '0) begin
          state_d = UPDATE;
        end else begin
          iter_d = iter_q - ITER_W'(1);
        end
      end
      UPDATE: begin
        thresh_d = quo_q[7:0];
        state_d  = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ACCUM;
      vsync_d_q <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      iter_q    <= '0;
      thresh_q  <= THRESH_DEFAULT;
      th_upd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_d_q <= in_vsync;
      sum_q     <= sum_d;
      count_q   <= count_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      iter_q    <= iter_d;
      thresh_q  <= thresh_d;
      th_upd_q  <= (state_d == UPDATE);
    end
  end

  assign thresh_cur = thresh_q;
  assign th_update  = th_upd_q;

`else

  assign thresh_cur = THRESH_DEFAULT;
  assign th_update  = 1'b0;

`endif

endmodule

`default_nettype wire

// File: tb/tb_grey_binarize.sv
// tb_grey_binarize: directed scenarios plus randomized frames against a frame-level model.
`default_nettype none

module tb_grey_binarize;

  localparam logic [7:0] THR = 8'd128;
  localparam int         CW  = 9;
  localparam int         SW  = CW + 8;
  localparam longint     SMAX = (longint'(1) << SW) - 1;
  localparam longint     CMAX = (longint'(1) << CW) - 1;
`ifdef GREY_BINARIZE_ADAPTIVE_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_href = 1'b0, in_vsync = 1'b0, in_clken = 1'b0;
  logic [7:0]  grey = 8'd0;
  logic [11:0] out_rgb;
  logic        out_href, out_vsync, out_clken;
  logic [7:0]  threshold;
  logic        th_update;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulse  = 0;

  always #5 clk = ~clk;

  grey_binarize #(.THRESH_DEFAULT(THR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_href(in_href), .in_vsync(in_vsync),
    .in_clken(in_clken), .grey(grey), .out_rgb(out_rgb), .out_href(out_href),
    .out_vsync(out_vsync), .out_clken(out_clken), .threshold(threshold),
    .th_update(th_update)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (per clock edge k) ----------------
  int         k = 8;
  logic [7:0] h_grey [4] = '{default: 8'd0};
  logic [7:0] h_thr  [4] = '{default: THR};
  logic [2:0] h_sync [4] = '{default: 3'd0};
  logic       h_rst  [4] = '{default: 1'b1};
  logic [7:0] m_thr = THR;
  logic [7:0] m_pend = 8'd0;
  logic       m_upd = 1'b0;
  bit         m_prev_vs = 1'b0, m_active = 1'b0;
  longint     m_sum = 0, m_cnt = 0, m_upd_edge = 0, m_thr_edge = 0;
  logic [11:0] e_rgb = 12'h0;
  logic [2:0]  e_sync = 3'd0;

  always @(posedge clk) begin : model
    bit rise, pix;
    k = k + 1;
    if (reset) begin
      m_sum = 0; m_cnt = 0; m_prev_vs = 0; m_active = 0; m_upd = 0; m_thr = THR;
      h_grey[k&3] = 8'd0; h_sync[k&3] = 3'd0; h_rst[k&3] = 1'b1; h_thr[k&3] = THR;
    end else begin
      rise = in_vsync && !m_prev_vs;
      pix  = in_href && in_clken;
      m_prev_vs = in_vsync;
      m_upd = 1'b0;
      if (ADAPT) begin
        if (rise) begin
          if (!m_active && m_cnt != 0) begin
            m_active   = 1'b1;
            m_pend     = 8'(m_sum / m_cnt);
            m_upd_edge = k + SW;
            m_thr_edge = k + SW + 1;
          end
          m_sum = pix ? longint'(grey) : 0;
          m_cnt = pix ? 1 : 0;
        end else if (pix) begin
          m_sum = m_sum + longint'(grey);
          if (m_sum > SMAX) m_sum = SMAX;
          m_cnt = m_cnt + 1;
          if (m_cnt > CMAX) m_cnt = CMAX;
        end
        if (m_active && k == m_upd_edge) m_upd = 1'b1;
        if (m_active && k == m_thr_edge) begin
          m_thr = m_pend;
          m_active = 1'b0;
        end
      end
      h_grey[k&3] = grey;
      h_sync[k&3] = {in_href, in_vsync, in_clken};
      h_rst[k&3]  = 1'b0;
      h_thr[k&3]  = m_thr;
    end
    // Output after edge k reflects the input seen at edge k-2, compared with the
    // threshold that was live between edges k-2 and k-1.
    if (h_rst[k&3] || h_rst[(k-1)&3]) begin
      e_rgb = 12'h000; e_sync = 3'd0;
    end else begin
      e_rgb  = (h_grey[(k-2)&3] >= h_thr[(k-2)&3]) ? 12'hFFF : 12'h000;
      e_sync = h_sync[(k-2)&3];
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("rst_rgb", out_rgb, 12'h000);
      check("rst_sync", {out_href, out_vsync, out_clken}, 3'd0);
      check("rst_thupd", th_update, 1'b0);
      check("rst_thr", threshold, THR);
    end else begin
      check("rgb", out_rgb, e_rgb);
      check("sync", {out_href, out_vsync, out_clken}, e_sync);
      check("thr", threshold, m_thr);
      check("thupd", th_update, m_upd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
    if (th_update) n_pulse++;
  endtask

  task automatic drv(input bit h, input bit v, input bit c, input logic [7:0] g);
    in_href = h; in_vsync = v; in_clken = c; grey = g;
    tick();
  endtask

  task automatic pixels(input int n, input logic [7:0] g);
    for (int i = 0; i < n; i++) drv(1'b1, 1'b0, 1'b1, g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic vs_pulse();
    drv(1'b0, 1'b1, 1'b0, 8'd0);
    drv(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_href = 0; in_vsync = 0; in_clken = 0; grey = 0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    do_reset();
    check("reset_thr", threshold, THR);
    check("reset_rgb", out_rgb, 12'h000);
    check("reset_thupd", th_update, 1'b0);

    // 127 then 128 against the default threshold, 3 cycles latency
    drv(1, 0, 1, 8'd127);
    drv(1, 0, 1, 8'd128);
    drv(0, 0, 0, 8'd0);
    check("s34_rgb127", out_rgb, 12'h000);
    check("s34_href127", out_href, 1'b1);
    drv(0, 0, 0, 8'd0);
    check("s34_rgb128", out_rgb, 12'hFFF);
    check("s34_clken128", out_clken, 1'b1);

    // 100 pixels at 60, then vsync rise: pulse latency and new threshold
    do_reset();
    n_pulse = 0;
    pixels(100, 8'd60);
    in_href = 0; in_clken = 0; in_vsync = 1;
    lat = 0; seen = 0;
    for (int i = 0; i < SW + 20; i++) begin
      tick();
      lat++;
      in_vsync = 0;
      if (th_update) begin seen = 1; break; end
    end
    idle(4);
    check("s35_latency", seen ? lat : 0, ADAPT ? SW + 1 : 0);
    check("s35_pulses", n_pulse, ADAPT ? 1 : 0);
    check("s35_thr", threshold, ADAPT ? 8'd60 : THR);

    // mean of 50x0 and 50x201 floors to 100
    pixels(50, 8'd0);
    pixels(50, 8'd201);
    vs_pulse();
    idle(SW + 5);
    check("s36_thr", threshold, ADAPT ? 8'd100 : THR);
    drv(1, 0, 1, 8'd100);
    drv(1, 0, 1, 8'd99);
    drv(0, 0, 0, 8'd0);
    check("s36_rgb100", out_rgb, ADAPT ? 12'hFFF : 12'h000);
    drv(0, 0, 0, 8'd0);
    check("s36_rgb99", out_rgb, 12'h000);

    // flush the 100/99 frame (mean 99), then an empty frame leaves it alone
    vs_pulse();
    idle(SW + 5);
    check("s37_thr_pre", threshold, ADAPT ? 8'd99 : THR);
    n_pulse = 0;
    vs_pulse();
    idle(SW + 5);
    check("s37_pulses", n_pulse, 0);
    check("s37_thr", threshold, ADAPT ? 8'd99 : THR);

    // second vsync 5 cycles into DIVIDE; pixel on that edge starts the next frame
    n_pulse = 0;
    pixels(20, 8'd40);
    drv(0, 1, 0, 8'd0);
    pixels(3, 8'd200);
    drv(0, 0, 0, 8'd0);
    drv(1, 1, 1, 8'd10);
    drv(1, 0, 1, 8'd50);
    idle(SW + 5);
    check("s38_pulses", n_pulse, ADAPT ? 1 : 0);
    check("s38_thr", threshold, ADAPT ? 8'd40 : THR);
    vs_pulse();
    idle(SW + 5);
    check("s38_next_thr", threshold, ADAPT ? 8'd30 : THR);

    // reset during DIVIDE abandons the division
    pixels(30, 8'd77);
    vs_pulse();
    idle(5);
    reset = 1'b1;
    tick();
    check("s39_rgb_in_reset", out_rgb, 12'h000);
    check("s39_thr_in_reset", threshold, THR);
    tick(); tick();
    reset = 1'b0;
    n_pulse = 0;
    idle(SW + 10);
    check("s39_pulses", n_pulse, 0);
    check("s39_thr", threshold, THR);

    // count and sum saturation: 600 x 255 -> 131071/511 = 256 -> low byte 0
    pixels(600, 8'd255);
    vs_pulse();
    idle(SW + 5);
    check("sat_thr", threshold, ADAPT ? 8'd0 : THR);

    // randomized frames with vsync rises landing anywhere, including in DIVIDE
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] g;
      g = (c % 600 < 300) ? 8'($urandom_range(0, 140)) : 8'($urandom_range(90, 255));
      in_href  = ($urandom % 4) != 0;
      in_clken = ($urandom % 3) != 0;
      in_vsync = ($urandom % 30) == 0;
      grey     = g;
      tick();
    end
    idle(SW + 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/grey_binarize.md
GREY_BINARIZE -- requirements
Module: grey_binarize

Interface
REQ-001 The block SHALL have parameter THRESH_DEFAULT, default 8'd128, setting the threshold after reset and in fixed mode.
REQ-002 The block SHALL have parameter CNT_W, default 17, setting the width of the pixel counter; the sum width is CNT_W+8.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_href  input  1  line-valid qualifier from the grey stage.
REQ-006 in_vsync  input  1  frame sync; the rising edge marks end of frame.
REQ-007 in_clken  input  1  pixel-valid strobe.
REQ-008 grey  input  8  grey pixel value.
REQ-009 out_rgb  output  12  RGB444 binarized pixel, registered.
REQ-010 out_href, out_vsync, out_clken  output  1 each  syncs delayed to align with out_rgb.
REQ-011 threshold  output  8  threshold currently in use, registered.
REQ-012 th_update  output  1  one-cycle pulse when threshold takes a new value.

Function
REQ-013 The pixel path SHALL be a 3-stage pipeline: stage 1 registers grey; stage 2 registers the comparison against threshold; stage 3 registers out_rgb.
REQ-014 out_rgb SHALL be 12'hFFF when the stage-1 grey >= threshold, else 12'h000, independent of the sync qualifiers.
REQ-015 in_href, in_vsync and in_clken SHALL each pass through a 3-deep shift register so they stay cycle-aligned with out_rgb.
REQ-016 A pixel SHALL be accumulated only when in_href=1 and in_clken=1.
REQ-017 Accumulation SHALL add grey into sum (CNT_W+8 bits) and increment count (CNT_W bits).
REQ-018 Both sum and count SHALL saturate at all-ones; they SHALL NOT wrap.
REQ-019 A rising edge of in_vsync SHALL be detected from a one-cycle-delayed copy of in_vsync.
REQ-020 The stats FSM SHALL have states ACCUM, DIVIDE and UPDATE; reset state is ACCUM.
REQ-021 On a vsync rising edge in ACCUM with count != 0, the block SHALL latch sum and count into divider registers, clear the accumulators in the same cycle, and go to DIVIDE.
REQ-022 On a vsync rising edge in ACCUM with count == 0, the block SHALL stay in ACCUM with threshold unchanged.
REQ-023 DIVIDE SHALL run an unsigned restoring division of one quotient bit per cycle, taking exactly CNT_W+8 cycles, then go to UPDATE.
REQ-024 UPDATE SHALL load threshold with the low 8 bits of the quotient, pulse th_update for one cycle, and return to ACCUM.
REQ-025 Accumulation of the next frame SHALL continue during DIVIDE and UPDATE.
REQ-026 A vsync rising edge during DIVIDE or UPDATE SHALL still clear the accumulators, but that frame's statistics are dropped and no new division starts.
REQ-027 A pixel qualifying on the same cycle as a vsync rising edge SHALL be the first pixel of the new accumulation.
REQ-028 A new threshold SHALL take effect on the stage-2 compare from the cycle after th_update.

Reset
REQ-029 While reset is asserted, the block SHALL clear all pipeline registers, out_rgb, out_href, out_vsync, out_clken, th_update, sum, count and the divider registers to 0.
REQ-030 Reset SHALL set threshold to THRESH_DEFAULT and the FSM to ACCUM.
REQ-031 Reset asserted mid-DIVIDE SHALL abandon the division with no threshold update.

Configuration
REQ-032 When macro GREY_BINARIZE_ADAPTIVE_EN is defined, the threshold SHALL be adaptive as specified in REQ-016 to REQ-028.
REQ-033 When GREY_BINARIZE_ADAPTIVE_EN is undefined, the accumulators, divider and FSM SHALL be absent, threshold SHALL be constant THRESH_DEFAULT, th_update SHALL be tied 0, and the pixel path SHALL be unchanged.

Verification
REQ-034 Scenario: after reset, feed grey 127 then 128 with href=clken=1 -> out_rgb 12'h000 then 12'hFFF, 3 cycles later; syncs aligned.
REQ-035 Scenario: one frame of 100 pixels at grey 60 then a vsync rise -> th_update pulses once CNT_W+8+1 cycles after the edge detect; threshold=60.
REQ-036 Scenario: frame mixing 50 pixels at 0 and 50 at 201 -> threshold=100 (floor of 100.5); next frame grey 100 -> 12'hFFF, grey 99 -> 12'h000.
REQ-037 Scenario: vsync rise with no qualifying pixels -> no th_update; threshold holds its prior value.
REQ-038 Scenario: a second vsync rise 5 cycles into DIVIDE -> exactly one th_update, carrying the first frame's mean; the next frame accumulates from 0.
REQ-039 Scenario: reset pulse mid-DIVIDE -> threshold=128, th_update stays 0, and out_* are 0 during reset.
